// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending counters drive stall, operand forwarding muxes.
// Optional HAZARD_PERF_EN adds a saturating stall_cycles performance counter output.
module hazard_scoreboard #(
    parameter int BITS       = 32,
    parameter int REG_WORDS  = 32,
    parameter int NUM_RD     = 2,
    parameter int FWD_STAGES = 3,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    localparam int AW        = $clog2(REG_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     id_valid,
    input  logic                     id_rw,
    input  logic                     id_load,
    input  logic [AW-1:0]            id_waddr,
    input  logic [NUM_RD*AW-1:0]     r_addr,
    input  logic [NUM_RD-1:0]        r_use,
    input  logic [NUM_RD*BITS-1:0]   rf_rdata,
    input  logic [FWD_STAGES-1:0]    fwd_valid,
    input  logic [FWD_STAGES*AW-1:0] fwd_waddr,
    input  logic [FWD_STAGES*BITS-1:0] fwd_data,
    output logic [NUM_RD*BITS-1:0]   rd_data,
`ifdef HAZARD_PERF_EN
    output logic [31:0]              stall_cycles,
`endif
    output logic [NUM_RD-1:0]        fwd_hit,
    output logic                     stall
);

    localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    logic [CW-1:0]   cnt_r [REG_WORDS];
    logic [AW-1:0]   raddr_s [NUM_RD];
    logic [BITS-1:0] rd_data_s [NUM_RD];
    logic [NUM_RD-1:0] hit_s;
    logic            stall_s;
    logic            issue_s;
    logic [CW-1:0]   lat_s;

    // Split the packed read-address bus into per-port addresses
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            raddr_s[i] = r_addr[i*AW +: AW];
        end
    end

    // A consumed operand whose register still has a pending producer holds decode
    always_comb begin
        stall_s = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (id_valid && r_use[i] && (raddr_s[i] != '0) &&
                (32'(raddr_s[i]) < REG_WORDS) && (cnt_r[raddr_s[i]] != '0)) begin
                stall_s = 1'b1;
            end else begin
                stall_s = stall_s;
            end
        end
    end

    assign issue_s = id_valid && !stall_s && id_rw && (id_waddr != '0);
    assign lat_s   = id_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);

    // Pending counters: issue reloads (wins over decrement), others count down to zero
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int r = 0; r < REG_WORDS; r++) begin
                cnt_r[r] <= '0;
            end
        end else begin
            for (int r = 1; r < REG_WORDS; r++) begin
                if (issue_s && (id_waddr == AW'(r)) && (lat_s != '0)) begin
                    cnt_r[r] <= lat_s;
                end else if (cnt_r[r] != '0) begin
                    cnt_r[r] <= cnt_r[r] - CW'(1);
                end
            end
        end
    end

    // Forward mux: scan oldest to youngest so the youngest matching stage wins
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_s[i] = rf_rdata[i*BITS +: BITS];
            hit_s[i]     = 1'b0;
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (fwd_valid[k] && (raddr_s[i] != '0) &&
                    (fwd_waddr[k*AW +: AW] == raddr_s[i])) begin
                    rd_data_s[i] = fwd_data[k*BITS +: BITS];
                    hit_s[i]     = 1'b1;
                end else begin
                    hit_s[i]     = hit_s[i];
                end
            end
        end
    end

    // Pack per-port forwarding results onto the output bus
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*BITS +: BITS] = rd_data_s[i];
        end
    end

    assign fwd_hit = hit_s;
    assign stall   = stall_s;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_r;

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
        end
    end

    assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios then randomized traffic
// compared against a ready-time reference model.
module tb_hazard_scoreboard;
    localparam int BITS = 32, REG_WORDS = 32, NUM_RD = 2, FWD_STAGES = 3;
    localparam int ALU_LAT = 1, LOAD_LAT = 2, AW = 5;

    logic clk, rst_;
    logic id_valid, id_rw, id_load;
    logic [AW-1:0] id_waddr;
    logic [NUM_RD*AW-1:0] r_addr;
    logic [NUM_RD-1:0] r_use;
    logic [NUM_RD*BITS-1:0] rf_rdata;
    logic [FWD_STAGES-1:0] fwd_valid;
    logic [FWD_STAGES*AW-1:0] fwd_waddr;
    logic [FWD_STAGES*BITS-1:0] fwd_data;
    logic [NUM_RD*BITS-1:0] rd_data;
    logic [NUM_RD-1:0] fwd_hit;
    logic stall;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    hazard_scoreboard #(
        .BITS(BITS), .REG_WORDS(REG_WORDS), .NUM_RD(NUM_RD), .FWD_STAGES(FWD_STAGES),
        .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk(clk), .rst_(rst_), .id_valid(id_valid), .id_rw(id_rw), .id_load(id_load),
        .id_waddr(id_waddr), .r_addr(r_addr), .r_use(r_use), .rf_rdata(rf_rdata),
        .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
        .rd_data(rd_data),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .fwd_hit(fwd_hit), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_until [REG_WORDS];
    int exp_perf = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < REG_WORDS; r++) busy_until[r] = -1;
        exp_perf = 0;
    endtask

    // A register is busy while the current cycle is within lat cycles of its producer's issue
    function automatic logic model_stall();
        logic [AW-1:0] a;
        for (int i = 0; i < NUM_RD; i++) begin
            a = r_addr[i*AW +: AW];
            if (id_valid && r_use[i] && a != 0 && cyc <= busy_until[a]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [BITS:0] model_port(input int i);
        logic [AW-1:0] a;
        a = r_addr[i*AW +: AW];
        for (int k = 0; k < FWD_STAGES; k++) begin
            if (a != 0 && fwd_valid[k] && fwd_waddr[k*AW +: AW] == a)
                return {1'b1, fwd_data[k*BITS +: BITS]};
        end
        return {1'b0, rf_rdata[i*BITS +: BITS]};
    endfunction

    task automatic settle();
        logic [BITS:0] m;
        #1;
        check("model_stall", stall, model_stall());
        for (int i = 0; i < NUM_RD; i++) begin
            m = model_port(i);
            check($sformatf("model_rd_data%0d", i), rd_data[i*BITS +: BITS], m[BITS-1:0]);
            check($sformatf("model_fwd_hit%0d", i), fwd_hit[i], m[BITS]);
        end
`ifdef HAZARD_PERF_EN
        check("model_stall_cycles", stall_cycles, exp_perf);
`endif
    endtask

    task automatic tick();
        logic st;
        @(posedge clk);
        st = model_stall();
        if (rst_) begin
            if (st) exp_perf++;
            if (id_valid && !st && id_rw && id_waddr != 0)
                busy_until[id_waddr] = cyc + (id_load ? LOAD_LAT : ALU_LAT);
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rw = 1'b0; id_load = 1'b0; id_waddr = '0;
        r_addr = '0; r_use = '0; fwd_valid = '0; fwd_waddr = '0; fwd_data = '0;
        rf_rdata = {$urandom, $urandom};
    endtask

    task automatic set_rd(input int i, input int a, input logic u);
        r_addr[i*AW +: AW] = AW'(a);
        r_use[i] = u;
    endtask

    task automatic issue(input int wa, input logic ld);
        idle();
        id_valid = 1'b1; id_rw = 1'b1; id_load = ld; id_waddr = AW'(wa);
    endtask

    initial begin
        idle();
        rst_ = 1'b0;
        clear_model();
        set_rd(0, 4, 1'b1);
        id_valid = 1'b1;
        settle();
        check("reset_stall", stall, 1'b0);
        tick();
        tick();
        rst_ = 1'b1;

        // Load followed by dependent read, twice
        for (int rep = 0; rep < 2; rep++) begin
            issue(5, 1'b1);
            settle(); check("lw_issue_stall", stall, 1'b0); tick();
            idle(); id_valid = 1'b1; set_rd(0, 5, 1'b1);
            settle(); check("lw_dep_stall1", stall, 1'b1); tick();
            settle(); check("lw_dep_stall2", stall, 1'b1); tick();
            settle(); check("lw_dep_release", stall, 1'b0); tick();
            idle(); settle(); tick();
        end
`ifdef HAZARD_PERF_EN
        check("perf_stall_cycles", stall_cycles, 32'd4);
`endif

        // ALU back-to-back: one bubble, then forwarded operand
        issue(3, 1'b0);
        settle(); tick();
        idle(); id_valid = 1'b1; set_rd(0, 3, 1'b1);
        settle(); check("alu_dep_stall", stall, 1'b1); tick();
        fwd_valid = 3'b001; fwd_waddr[0 +: AW] = 5'd3; fwd_data[0 +: BITS] = 32'hDEAD_BEEF;
        settle();
        check("alu_dep_release", stall, 1'b0);
        check("alu_fwd_data", rd_data[0 +: BITS], 32'hDEAD_BEEF);
        check("alu_fwd_hit", fwd_hit[0], 1'b1);
        tick();

        // Youngest forwarding stage has priority
        idle();
        set_rd(0, 7, 1'b0); set_rd(1, 7, 1'b1);
        fwd_waddr = {5'd7, 5'd7, 5'd7};
        fwd_data = {32'h0000_0022, 32'h0000_0033, 32'h0000_0011};
        fwd_valid = 3'b101;
        settle();
        check("prio_rd0", rd_data[0 +: BITS], 32'h0000_0011);
        check("prio_rd1", rd_data[BITS +: BITS], 32'h0000_0011);
        fwd_valid = 3'b100;
        settle(); check("prio_stage2", rd_data[0 +: BITS], 32'h0000_0022);
        fwd_valid = 3'b110;
        settle(); check("prio_stage1", rd_data[0 +: BITS], 32'h0000_0033);
        tick();

        // Register 0 is never tracked nor forwarded
        issue(0, 1'b1);
        settle(); tick();
        idle(); id_valid = 1'b1; set_rd(0, 0, 1'b1);
        rf_rdata = {32'hCAFE_0001, 32'hCAFE_0000};
        fwd_valid = 3'b001; fwd_waddr[0 +: AW] = 5'd0; fwd_data[0 +: BITS] = 32'h0000_0055;
        settle();
        check("r0_stall", stall, 1'b0);
        check("r0_fwd_hit", fwd_hit[0], 1'b0);
        check("r0_rd_data", rd_data[0 +: BITS], 32'hCAFE_0000);
        tick();

        // Reset mid-countdown discards the pending load
        issue(9, 1'b1);
        settle(); tick();
        idle(); rst_ = 1'b0; clear_model();
        settle(); tick();
        rst_ = 1'b1;
        idle(); id_valid = 1'b1; set_rd(1, 9, 1'b1);
        settle(); check("rst_mid_stall", stall, 1'b0); tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            id_valid = ($urandom_range(0, 3) != 0);
            id_rw = $urandom_range(0, 1);
            id_load = $urandom_range(0, 1);
            id_waddr = AW'($urandom_range(0, 7));
            for (int i = 0; i < NUM_RD; i++) set_rd(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            fwd_valid = FWD_STAGES'($urandom);
            for (int k = 0; k < FWD_STAGES; k++) begin
                fwd_waddr[k*AW +: AW] = AW'($urandom_range(0, 7));
                fwd_data[k*BITS +: BITS] = $urandom;
            end
            if ($urandom_range(0, 99) == 0) begin
                rst_ = 1'b0;
                clear_model();
                settle(); tick();
                rst_ = 1'b1;
            end else begin
                settle(); tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter BITS, default 32, datapath width.
REQ-002 SHALL have parameter REG_WORDS, default 32, register count; register address width AW = $clog2(REG_WORDS).
REQ-003 SHALL have parameter NUM_RD, default 2, number of decode read ports.
REQ-004 SHALL have parameter FWD_STAGES, default 3, number of forwarding sources; index 0 is youngest.
REQ-005 SHALL have parameter ALU_LAT, default 1, cycles after issue before a non-load result is on a forwarding bus.
REQ-006 SHALL have parameter LOAD_LAT, default 2, the same latency for loads; constraint LOAD_LAT >= ALU_LAT >= 0.
REQ-007 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-008 SHALL have port rst_, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port id_valid, input, 1, decode holds a valid instruction.
REQ-010 SHALL have port id_rw, input, 1, decode instruction writes a register.
REQ-011 SHALL have port id_load, input, 1, decode instruction is a load.
REQ-012 SHALL have port id_waddr, input, AW, decode destination register.
REQ-013 SHALL have port r_addr, input, NUM_RD*AW, decode read addresses, port i at slice i.
REQ-014 SHALL have port r_use, input, NUM_RD, per-port "operand consumed" flag (covers jr and beq/bne operands).
REQ-015 SHALL have port rf_rdata, input, NUM_RD*BITS, register file read data per port.
REQ-016 SHALL have ports fwd_valid (FWD_STAGES), fwd_waddr (FWD_STAGES*AW) and fwd_data (FWD_STAGES*BITS), all inputs, carrying per-stage result write-back info.
REQ-017 SHALL have port rd_data, output, NUM_RD*BITS, forwarded operand per port.
REQ-018 SHALL have port fwd_hit, output, NUM_RD, set when port i took forwarded data.
REQ-019 SHALL have port stall, output, 1, hold decode and freeze fetch.

Function
REQ-020 SHALL keep a per-register pending counter cnt[r], wide enough to hold LOAD_LAT; register 0 SHALL never be tracked and cnt[0] SHALL read 0.
REQ-021 SHALL define issue = id_valid && !stall && id_rw && id_waddr != 0.
REQ-022 On issue, SHALL load cnt[id_waddr] with LOAD_LAT if id_load, else with ALU_LAT; if the selected latency is 0, no entry SHALL be made.
REQ-023 Each cycle, every other nonzero counter SHALL decrement by 1 and SHALL saturate at 0.
REQ-024 On a same-cycle decrement and issue to the same register, the issue load value SHALL win.
REQ-025 stall SHALL be combinational: 1 iff id_valid and, for some port i, r_use[i] is set, r_addr[i] != 0 and cnt[r_addr[i]] != 0.
REQ-026 rd_data[i] SHALL take fwd_data[k] for the lowest k with fwd_valid[k] set, fwd_waddr[k] == r_addr[i] and r_addr[i] != 0, and fwd_hit[i] SHALL be 1; otherwise rd_data[i] SHALL be rf_rdata[i] and fwd_hit[i] SHALL be 0.
REQ-027 Forwarding SHALL have zero latency, is independent of r_use, and SHALL always be computed even while stall is 1.
REQ-028 A consumer issued N cycles after its producer SHALL stall for max(0, lat-N+1) cycles, where lat is the producer's latency; ALU_LAT=1 therefore gives one bubble back-to-back.

Reset
REQ-029 While rst_ is low, all cnt SHALL be 0; stall SHALL be 0 unless inputs request it (no pending entries); perf counter SHALL be 0.
REQ-030 Reset asserted mid-countdown SHALL discard all pending entries immediately, with no deferred stall after release.

Configuration
REQ-031 When macro HAZARD_PERF_EN is defined, the block SHALL add output stall_cycles (32 bits), which increments on each clk where stall=1 and saturates at 32'hFFFF_FFFF.
REQ-032 Without HAZARD_PERF_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL check load then dependent read: issue lw r5 (LOAD_LAT=2), then next cycle r_addr0=5 with r_use0=1 -> stall=1 for 2 cycles, then 0.
REQ-034 The bench SHALL check ALU back-to-back: add r3, then next cycle read r3 -> stall=1 for exactly 1 cycle; after that, with fwd_valid[0]=1, fwd_waddr[0]=3 and fwd_data[0]=32'hDEAD_BEEF, rd_data0=32'hDEAD_BEEF and fwd_hit0=1.
REQ-035 The bench SHALL check priority: fwd stages 0 and 2 both target r7 with data 32'h11 and 32'h22 -> rd_data=32'h11.
REQ-036 The bench SHALL check register 0: issue lw r0, then read r0 -> stall=0, fwd_hit=0 and rd_data=rf_rdata.
REQ-037 The bench SHALL check reset mid-op: issue lw r9, drop rst_ for 1 cycle, then read r9 -> stall=0.
REQ-038 The bench SHALL check perf (HAZARD_PERF_EN): run the REQ-033 sequence twice -> stall_cycles=4.
